// File: rtl/gj_inv_pkg.sv
// Shared types and helpers for the Gauss-Jordan matrix inverter.
// Default geometry is N=4, Q8.8 elements.
package gj_inv_pkg;

    localparam int N_DEF    = 4;
    localparam int W_DEF    = 16;
    localparam int FRAC_DEF = 8;
    localparam int ONE      = 1 << FRAC_DEF;

    typedef enum logic [2:0] {
        S_LOAD,
        S_SEARCH,
        S_SWAP,
        S_RECIP,
        S_NORM,
        S_ELIM,
        S_OUTPUT
    } state_t;

    // Clamp a wide signed value into the w-bit two's complement range.
    function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

endpackage

// File: rtl/gj_recip_div.sv
// Sequential restoring divider computing (1 << 2*FRAC) / divisor, one quotient
// bit per cycle, truncated toward zero and saturated to W bits.
module gj_recip_div
    import gj_inv_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic signed [W-1:0] divisor,
    output logic                done,
    output logic signed [W-1:0] quotient
);

    localparam int QW   = W + FRAC + 1;
    localparam int CNTW = $clog2(QW + 1);

    logic [QW-1:0]   dvd;
    logic [QW-1:0]   quo;
    logic [W-1:0]    dvs;
    logic [W-1:0]    rem;
    logic            neg;
    logic [CNTW-1:0] cnt;
    logic [W:0]      trial;
    logic signed [63:0] sq;

    assign trial = {rem, dvd[QW-1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            dvd  <= '0;
            quo  <= '0;
            dvs  <= '0;
            rem  <= '0;
            neg  <= 1'b0;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                dvd <= QW'(1) << (2 * FRAC);
                quo <= '0;
                rem <= '0;
                neg <= divisor[W-1];
                // The magnitude of the most negative value still fits unsigned.
                dvs <= divisor[W-1] ? W'(-divisor) : W'(divisor);
                cnt <= CNTW'(QW);
            end else if (cnt != '0) begin
                if (trial >= {1'b0, dvs}) begin
                    rem <= W'(trial - {1'b0, dvs});
                    quo <= {quo[QW-2:0], 1'b1};
                end else begin
                    rem <= trial[W-1:0];
                    quo <= {quo[QW-2:0], 1'b0};
                end
                dvd  <= dvd << 1;
                cnt  <= cnt - 1'b1;
                done <= (cnt == CNTW'(1));
            end
        end
    end

    always_comb begin
        sq       = neg ? -64'(quo) : 64'(quo);
        quotient = W'(sat(sq, W));
    end

endmodule

// File: rtl/gj_matrix_inverse.sv
// Streamed N x N fixed-point Gauss-Jordan inverter over an [A | I] working array,
// with first-nonzero pivoting and a singular flag carried on every output beat.
module gj_matrix_inverse
    import gj_inv_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int W    = W_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         singular,
    output logic         busy
);

    localparam int RW  = $clog2(N);
    localparam int RW1 = RW + 1;
    localparam int CW  = $clog2(2 * N);
    localparam logic signed [W-1:0] ONE_Q = W'(1) << FRAC;

    state_t state, state_d;

    logic signed [W-1:0] a [N][2*N];
    logic [RW-1:0]       k, r;
    logic [CW-1:0]       c;
    logic                ph;
    logic signed [W-1:0] f, recip, div_q;
    logic                sing, div_start, div_done;

    logic                accept, half_end, load_end, col_end, piv_nz, rows_done, out_fire;
    logic [RW1-1:0]      row_next;
    logic signed [2*W-1:0] prod_n, prod_e;
    logic signed [W-1:0] norm_val, elim_val;

    gj_recip_div #(.W(W), .FRAC(FRAC)) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .divisor  (a[k][CW'(k)]),
        .done     (div_done),
        .quotient (div_q)
    );

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        accept    = in_valid && in_ready;
        half_end  = (c == CW'(N - 1));
        load_end  = half_end && (r == RW'(N - 1));
        col_end   = (c == CW'(2 * N - 1));
        piv_nz    = (a[r][CW'(k)] != '0);
        row_next  = RW1'(r) + RW1'(1);
        if (row_next == RW1'(k))
            row_next = row_next + RW1'(1);
        rows_done = (row_next >= RW1'(N));
        out_fire  = out_valid && out_ready;
        prod_n    = a[k][c] * recip;
        prod_e    = f * a[k][c];
        norm_val  = W'(sat(64'(prod_n >>> FRAC), W));
        elim_val  = W'(sat(64'(a[r][c]) - 64'(prod_e >>> FRAC), W));
    end

    always_comb begin
        state_d  = state;
        in_ready = (state == S_LOAD);
        busy     = (state != S_LOAD);
        unique case (state)
            S_LOAD:   if (accept && load_end) state_d = S_SEARCH;
            S_SEARCH: begin
                if (piv_nz)
                    state_d = (r == k) ? S_RECIP : S_SWAP;
                else if (r == RW'(N - 1))
                    state_d = S_OUTPUT;
            end
            S_SWAP:   if (col_end) state_d = S_RECIP;
            S_RECIP:  if (div_done) state_d = S_NORM;
            S_NORM:   if (col_end) state_d = S_ELIM;
            S_ELIM:   if (ph && col_end && rows_done)
                          state_d = (k == RW'(N - 1)) ? S_OUTPUT : S_SEARCH;
            S_OUTPUT: if (out_fire && out_last) state_d = S_LOAD;
            default:  state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_LOAD;
        else       state <= state_d;
    end

    // NOTE: the working array is deliberately left out of reset; a load always
    // rewrites every cell before it is read, so resetting it would only cost area.
    always_ff @(posedge clk) begin
        div_start <= 1'b0;
        if (reset) begin
            k         <= '0;
            r         <= '0;
            c         <= '0;
            ph        <= 1'b0;
            f         <= '0;
            recip     <= '0;
            sing      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            singular  <= 1'b0;
        end else begin
            unique case (state)
                S_LOAD: if (accept) begin
                    a[r][c]            <= in_data;
                    a[r][c + CW'(N)]   <= (CW'(r) == c) ? ONE_Q : '0;
                    c                  <= half_end ? '0 : c + 1'b1;
                    r                  <= load_end ? '0 : (half_end ? r + 1'b1 : r);
                    k                  <= '0;
                end
                S_SEARCH: begin
                    if (piv_nz) begin
                        c         <= '0;
                        div_start <= (r == k);
                    end else if (r == RW'(N - 1)) begin
                        sing <= 1'b1;
                        r    <= '0;
                        c    <= '0;
                    end else begin
                        r <= r + 1'b1;
                    end
                end
                S_SWAP: begin
                    // NOTE: non-blocking assignments make this a true exchange;
                    // both sides read the pre-edge values.
                    a[k][c]   <= a[r][c];
                    a[r][c]   <= a[k][c];
                    c         <= col_end ? '0 : c + 1'b1;
                    div_start <= col_end;
                end
                S_RECIP: if (div_done) begin
                    recip <= div_q;
                    c     <= '0;
                end
                S_NORM: begin
                    a[k][c] <= norm_val;
                    c       <= col_end ? '0 : c + 1'b1;
                    if (col_end) begin
                        r  <= (k == '0) ? RW'(1) : '0;
                        ph <= 1'b0;
                    end
                end
                S_ELIM: begin
                    if (!ph) begin
                        f  <= a[r][CW'(k)];
                        ph <= 1'b1;
                    end else begin
                        a[r][c] <= elim_val;
                        c       <= col_end ? '0 : c + 1'b1;
                        if (col_end) begin
                            ph <= 1'b0;
                            if (rows_done) begin
                                k <= k + 1'b1;
                                r <= (k == RW'(N - 1)) ? '0 : k + 1'b1;
                            end else begin
                                r <= RW'(row_next);
                            end
                        end
                    end
                end
                S_OUTPUT: begin
                    if (!out_valid || (out_ready && !out_last)) begin
                        out_valid <= 1'b1;
                        out_data  <= sing ? '0 : a[r][c + CW'(N)];
                        out_last  <= (r == RW'(N - 1)) && half_end;
                        singular  <= sing;
                        c         <= half_end ? '0 : c + 1'b1;
                        r         <= half_end ? r + 1'b1 : r;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        singular  <= 1'b0;
                        sing      <= 1'b0;
                        r         <= '0;
                        c         <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gj_matrix_inverse.sv
// Directed and randomized bench for gj_matrix_inverse against a plain integer
// Gauss-Jordan reference model.
module tb_gj_matrix_inverse;
    import gj_inv_pkg::*;

    localparam int N    = N_DEF;
    localparam int W    = W_DEF;
    localparam int FRAC = FRAC_DEF;
    localparam int NN   = N * N;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         singular;
    logic         busy;

    int           tests = 0;
    int           fails = 0;
    longint       mat [N][N];
    longint       expv [NN];
    bit           exp_sing;
    logic [W-1:0] got [NN];
    logic         got_sing;

    gj_matrix_inverse #(.N(N), .W(W), .FRAC(FRAC)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .singular  (singular),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic longint satm(input longint x);
        longint hi, lo;
        hi = (longint'(1) << (W - 1)) - 1;
        lo = -(longint'(1) << (W - 1));
        return (x > hi) ? hi : ((x < lo) ? lo : x);
    endfunction

    // Reference: textbook Gauss-Jordan on [A | I] using the fixed-point rules.
    task automatic model();
        longint g [N][2*N];
        longint recip, f, t;
        int     p;
        exp_sing = 1'b0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < 2 * N; j++)
                g[i][j] = (j < N) ? mat[i][j] : ((j - N == i) ? longint'(ONE) : 0);
        for (int k = 0; k < N; k++) begin
            p = -1;
            for (int rr = N - 1; rr >= k; rr--)
                if (g[rr][k] != 0) p = rr;
            if (p < 0) begin
                exp_sing = 1'b1;
                break;
            end
            if (p != k)
                for (int j = 0; j < 2 * N; j++) begin
                    t = g[k][j]; g[k][j] = g[p][j]; g[p][j] = t;
                end
            recip = satm((longint'(1) << (2 * FRAC)) / g[k][k]);
            for (int j = 0; j < 2 * N; j++)
                g[k][j] = satm((g[k][j] * recip) >>> FRAC);
            for (int rr = 0; rr < N; rr++) begin
                if (rr == k) continue;
                f = g[rr][k];
                for (int j = 0; j < 2 * N; j++)
                    g[rr][j] = satm(g[rr][j] - ((f * g[k][j]) >>> FRAC));
            end
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                expv[i*N + j] = exp_sing ? 0 : g[i][j + N];
    endtask

    task automatic set_identity();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                mat[i][j] = (i == j) ? longint'(ONE) : 0;
    endtask

    task automatic set_dominant();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (i == j)
                    mat[i][j] = longint'($urandom_range(256, 1024)) * (($urandom_range(0, 1) == 1) ? -1 : 1);
                else
                    mat[i][j] = longint'($urandom_range(0, 128)) - 64;
    endtask

    task automatic load_matrix(input string tag);
        int cyc;
        for (int i = 0; i < NN; i++) begin
            in_valid = 1'b1;
            in_data  = W'(mat[i / N][i % N]);
            cyc = 0;
            while (!in_ready && cyc < 1000) begin
                @(posedge clk); #1;
                cyc++;
            end
            if (i == 0) check({tag, "_ready"}, in_ready, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check({tag, "_busy"}, busy, 1);
        check({tag, "_noready"}, in_ready, 0);
    endtask

    task automatic collect(input string tag, input bit stall);
        int           cyc, beat;
        bit           rdy, held;
        logic [W-1:0] held_data, e;
        beat = 0; cyc = 0; held = 1'b0; held_data = '0;
        in_valid = 1'b1;
        in_data  = W'($urandom);
        while (beat < NN && cyc < 4000) begin
            if (held) check({tag, "_hold"}, out_data, held_data);
            rdy = stall ? cyc[0] : 1'b1;
            out_ready = rdy;
            if (out_valid && rdy) begin
                e = W'(expv[beat]);
                check({tag, "_data"}, out_data, e);
                check({tag, "_sing"}, singular, exp_sing);
                check({tag, "_last"}, out_last, beat == NN - 1);
                got[beat] = out_data;
                got_sing  = singular;
                if (beat == NN - 1) in_valid = 1'b0;
                beat++;
            end
            held      = out_valid && !rdy;
            held_data = out_data;
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, "_beats"}, beat, NN);
        check({tag, "_back_to_load"}, in_ready, 1);
        check({tag, "_idle"}, out_valid, 0);
    endtask

    task automatic run_case(input string tag, input bit stall);
        model();
        load_matrix(tag);
        collect(tag, stall);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_singular", singular, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        set_identity();
        run_case("ident", 1'b0);
        check("ident_diag0", got[0], 16'h0100);
        check("ident_off1", got[1], 16'h0000);

        set_identity();
        mat[0][0] = 'h200; mat[1][1] = 'h400; mat[2][2] = 'h080; mat[3][3] = 'h100;
        run_case("diag", 1'b0);
        check("diag_d0", got[0], 16'h0080);
        check("diag_d1", got[5], 16'h0040);
        check("diag_d2", got[10], 16'h0200);
        check("diag_d3", got[15], 16'h0100);

        set_identity();
        mat[0][0] = 0; mat[0][1] = ONE; mat[1][0] = ONE; mat[1][1] = 0;
        run_case("perm", 1'b0);
        check("perm_01", got[1], 16'h0100);
        check("perm_10", got[4], 16'h0100);
        check("perm_00", got[0], 16'h0000);

        set_dominant();
        for (int j = 0; j < N; j++) mat[2][j] = 0;
        run_case("singular", 1'b0);
        check("singular_flag", got_sing, 1);

        set_dominant();
        run_case("after_sing", 1'b0);
        check("after_sing_flag", got_sing, 0);

        set_identity();
        run_case("stall", 1'b1);

        set_identity();
        load_matrix("rst_mid");
        repeat (45) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_mid_ready", in_ready, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_valid", out_valid, 0);
        set_identity();
        run_case("post_rst", 1'b0);

        for (int n = 0; n < 3; n++) begin
            set_dominant();
            run_case("rand_dom", n[0]);
        end
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    mat[i][j] = ($urandom_range(0, 1) == 1) ? 0 : longint'($urandom_range(0, 1023)) - 512;
            run_case("rand_sparse", 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gj_matrix_inverse.md
# gj_matrix_inverse

Parametrised sequential Gauss-Jordan inverter for an N×N signed fixed-point matrix. It holds the matrix and an identity matrix side by side as one augmented working array. It uses partial pivoting (row swap on a zero pivot), one reciprocal divide per column and one multiply-subtract per cycle. It replaces the fixed 5×5 integer-only, single-cycle inverter in the linear-algebra datapath: the matrix arrives as a stream, the result leaves as a stream, and a flag reports a singular input.

## Interface
- N, 4, matrix dimension (2..8)
- W, 16, element width, signed two's complement
- FRAC, 8, fractional bits (Q(W-FRAC).FRAC), FRAC < W

- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- in_valid  in  1  input element valid
- in_ready  out  1  block accepts input (LOAD state)
- in_data  in  W  matrix element, row-major
- out_valid  out  1  result element valid
- out_ready  in  1  downstream accepts result
- out_data  out  W  inverse element, row-major
- out_last  out  1  marks element N*N-1
- singular  out  1  valid with every output beat; 1 = no inverse, data is zero
- busy  out  1  high in every state except LOAD

## Operation
- States: LOAD → SEARCH → SWAP → RECIP → NORM → ELIM → (next column: SEARCH | done: OUTPUT) → LOAD.
- LOAD
  - Accept N*N elements, one per cycle when in_valid && in_ready.
  - Write A[r][c]; initialise the right half to identity (1<<FRAC on the diagonal).
  - The accept of element N*N-1 moves the block to SEARCH for column k=0.
- SEARCH
  - Scan rows r=k..N-1, one per cycle, for the first A[r][k] ≠ 0.
  - If r=k, go to RECIP.
  - If r>k, go to SWAP.
  - If no row is found, set the singular latch and go to OUTPUT.
- SWAP: exchange rows k and r, one augmented column per cycle (2N cycles).
- RECIP: pass the pivot to the divider, which returns recip = (1<<2·FRAC)/pivot, truncated toward zero and saturated to W bits.
- NORM: A[k][j] = sat((A[k][j]·recip) >>> FRAC) for j=0..2N-1, one per cycle.
- ELIM: for each row r≠k:
  - latch f=A[r][k] (1 cycle);
  - then A[r][j] = sat(A[r][j] − ((f·A[k][j]) >>> FRAC)), j=0..2N-1.
  - After row N-1 (skipping k), increment k. If k=N go to OUTPUT, otherwise go to SEARCH.
- Arithmetic rules:
  - Products are full 2W-bit.
  - >>> is an arithmetic shift (floor).
  - sat clamps to [−2^(W-1), 2^(W-1)−1].
- OUTPUT
  - Stream the right half, row-major, N*N beats.
  - If singular is set, out_data=0 on every beat.
  - out_last is high on the final beat. Its handshake returns the block to LOAD and clears the singular latch.

## Timing
- Reset values: in_ready=1 (state LOAD), out_valid=0, out_data=0, out_last=0, singular=0, busy=0. k, the row/column counters and the singular latch are cleared.
- Reset in any state, including mid-stream, aborts the operation on that edge. The working array contents are don't-care; the next load overwrites them.
- Input: in_ready is high exactly in LOAD. There is no combinational path from in_valid to in_ready.
- Output handshake:
  - out_valid, out_data, out_last and singular are registered.
  - While out_valid && !out_ready, all of them hold stable.
  - The next element is presented the cycle after a handshake, so full throughput is 1 beat/cycle.
- Divider: sequential, W+FRAC+1 cycles, start/done pulse interface.
- Latency per column with no swap: 1 + (W+FRAC+1) + 2N + (N−1)(2N+1) cycles. A swap adds 2N cycles plus the extra search cycles.
- Defaults with no swaps: 4×(1+25+8+27) = 244 cycles from the last input accept to the first out_valid, plus 1 transition cycle.
- Simultaneous events:
  - No input is accepted while busy.
  - in_valid during OUTPUT is ignored.

## Structure
- Package gj_inv_pkg holds:
  - the state enum;
  - the default N/W/FRAC localparams;
  - the sat() function;
  - the ONE constant (1<<FRAC).
- Sub-module gj_recip_div: restoring unsigned divider with sign fixup, parameters W and FRAC, ports clk, reset, start, divisor, done, quotient.
- The working array is an internal register file, N×2N×W bits.

## Test plan
- Identity, N=4, Q8.8: diagonal 0x0100 → 16 beats; diagonal 0x0100, rest 0; singular=0; out_last on beat 15.
- Diagonal 0x0200, 0x0400, 0x0080, 0x0100 → diagonal 0x0080, 0x0040, 0x0200, 0x0100.
- Permutation with rows 0 and 1 swapped (A[0][0]=0) → SWAP exercised; output equals the input permutation.
- Row 2 all zero → singular=1 on all 16 beats, out_data=0; the next matrix loads and inverts normally.
- out_ready toggled 1/0 every cycle on the identity case → data holds while stalled; 16 beats in order, none lost.
- Reset asserted during ELIM, then an identity load → in_ready=1 the cycle after reset; a correct identity result follows.
